// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction-memory read bus between fetch stage and imem
interface fetch_stage_if;
   logic [7:0]  imem_addr;
   logic [31:0] imem_instr;

   modport master (output imem_addr, input imem_instr);
   modport slave  (input imem_addr, output imem_instr);
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RISC-V fetch stage: PC, imem address, IF/ID register (optional FETCH_MISALIGN_TRAP_EN)
module fetch_stage #(
   parameter logic [7:0]  RESET_PC  = 8'h00,
   parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             redirect_valid,
   input  logic [7:0]       redirect_pc,
   fetch_stage_if.master    imem,
   output logic             if_id_valid,
   output logic [31:0]      if_id_instr,
   output logic [7:0]       if_id_pc,
   output logic [7:0]       if_id_pc_plus4,
   output logic [15:0]      fetch_count,
   output logic             misalign_err
);

   logic [7:0]  pc_q, pc_d;
   logic        valid_q, valid_d;
   logic [31:0] instr_q, instr_d;
   logic [7:0]  ifpc_q, ifpc_d;
   logic [7:0]  ifpc4_q, ifpc4_d;
   logic [15:0] count_q, count_d;

   // next-state selection: redirect beats stall beats normal advance
   always_comb begin
      pc_d    = pc_q;
      valid_d = valid_q;
      instr_d = instr_q;
      ifpc_d  = ifpc_q;
      ifpc4_d = ifpc4_q;
      count_d = count_q;
      if (redirect_valid) begin
         // low bits dropped so pc stays word-aligned; fetched slot becomes a bubble
         pc_d    = {redirect_pc[7:2], 2'b00};
         valid_d = 1'b0;
         instr_d = NOP_INSTR;
      end else if (!stall) begin
         pc_d    = pc_q + 8'd4;
         valid_d = 1'b1;
         instr_d = imem.imem_instr;
         ifpc_d  = pc_q;
         ifpc4_d = pc_q + 8'd4;
         count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
      end
   end

   // PC and IF/ID pipeline register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q    <= RESET_PC;
         valid_q <= 1'b0;
         instr_q <= NOP_INSTR;
         ifpc_q  <= 8'h00;
         ifpc4_q <= 8'h04;
         count_q <= 16'h0000;
      end else begin
         pc_q    <= pc_d;
         valid_q <= valid_d;
         instr_q <= instr_d;
         ifpc_q  <= ifpc_d;
         ifpc4_q <= ifpc4_d;
         count_q <= count_d;
      end
   end

`ifdef FETCH_MISALIGN_TRAP_EN
   logic misalign_q, misalign_d;

   // sticky until reset once a redirect target has nonzero low bits
   always_comb begin
      misalign_d = misalign_q;
      if (redirect_valid && (redirect_pc[1:0] != 2'b00))
         misalign_d = 1'b1;
   end

   // misaligned-redirect flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) misalign_q <= 1'b0;
      else     misalign_q <= misalign_d;
   end

   assign misalign_err = misalign_q;
`else
   logic unused_redirect_low;
   assign unused_redirect_low = ^redirect_pc[1:0];
   assign misalign_err = 1'b0;
`endif

   assign imem.imem_addr  = pc_q;
   assign if_id_valid     = valid_q;
   assign if_id_instr     = instr_q;
   assign if_id_pc        = ifpc_q;
   assign if_id_pc_plus4  = ifpc4_q;
   assign fetch_count     = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage
module tb_fetch_stage;

   localparam logic [31:0] NOP = 32'h00000013;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [7:0]  redirect_pc = 8'h00;
   logic        if_id_valid;
   logic [31:0] if_id_instr;
   logic [7:0]  if_id_pc;
   logic [7:0]  if_id_pc_plus4;
   logic [15:0] fetch_count;
   logic        misalign_err;

   logic [31:0] mem [0:63];

   fetch_stage_if imem ();
   assign imem.imem_instr = mem[imem.imem_addr[7:2]];

   fetch_stage dut (
      .clk            (clk),
      .rst            (rst),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem           (imem.master),
      .if_id_valid    (if_id_valid),
      .if_id_instr    (if_id_instr),
      .if_id_pc       (if_id_pc),
      .if_id_pc_plus4 (if_id_pc_plus4),
      .fetch_count    (fetch_count),
      .misalign_err   (misalign_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  addr;
      logic        valid;
      logic [31:0] instr;
      logic [7:0]  pc;
      logic [7:0]  pc4;
      logic [15:0] cnt;
      logic        err;
   } exp_t;

   exp_t sb [$];
   int total = 0;
   int bad = 0;

`ifdef FETCH_MISALIGN_TRAP_EN
   localparam bit TRAP_EN = 1'b1;
`else
   localparam bit TRAP_EN = 1'b0;
`endif

   // reference model state
   logic [7:0]  m_pc;
   logic        m_valid;
   logic [31:0] m_instr;
   logic [7:0]  m_ifpc;
   logic [7:0]  m_ifpc4;
   logic [15:0] m_cnt;
   logic        m_err;

   task automatic model_reset();
      m_pc = 8'h00; m_valid = 1'b0; m_instr = NOP; m_ifpc = 8'h00;
      m_ifpc4 = 8'h04; m_cnt = 16'h0000; m_err = 1'b0;
   endtask

   task automatic model_edge(input logic s, input logic rv, input logic [7:0] rp);
      if (rv) begin
         m_valid = 1'b0;
         m_instr = NOP;
         m_pc = rp & 8'hFC;
         if (TRAP_EN && rp[1:0] != 2'b00) m_err = 1'b1;
      end else if (!s) begin
         m_valid = 1'b1;
         m_instr = mem[m_pc >> 2];
         m_ifpc = m_pc;
         m_ifpc4 = m_pc + 8'd4;
         m_pc = m_pc + 8'd4;
         if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end
   endtask

   task automatic push_model();
      exp_t e;
      e.addr = m_pc; e.valid = m_valid; e.instr = m_instr; e.pc = m_ifpc;
      e.pc4 = m_ifpc4; e.cnt = m_cnt; e.err = m_err;
      sb.push_back(e);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic pop_check(input string tag);
      exp_t e;
      total++;
      assert (sb.size() > 0) else begin
         bad++;
         $error("FAIL %s scoreboard_empty observed=0 expected=1", tag);
      end
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check({tag, ".addr"},  {24'h0, imem.imem_addr}, {24'h0, e.addr});
         check({tag, ".valid"}, {31'h0, if_id_valid},    {31'h0, e.valid});
         check({tag, ".instr"}, if_id_instr,             e.instr);
         check({tag, ".pc"},    {24'h0, if_id_pc},       {24'h0, e.pc});
         check({tag, ".pc4"},   {24'h0, if_id_pc_plus4}, {24'h0, e.pc4});
         check({tag, ".cnt"},   {16'h0, fetch_count},    {16'h0, e.cnt});
         check({tag, ".err"},   {31'h0, misalign_err},   {31'h0, e.err});
      end
   endtask

   // drive one edge's inputs, predict, then compare just after the edge
   task automatic step(input string tag, input logic s, input logic rv, input logic [7:0] rp);
      stall = s; redirect_valid = rv; redirect_pc = rp;
      model_edge(s, rv, rp);
      push_model();
      @(posedge clk);
      #1;
      pop_check(tag);
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'hA5000000 | (i << 8) | i;
      mem[0] = 32'h00007033;
      mem[1] = 32'h00100093;
      mem[2] = 32'h00200113;

      // reset state
      model_reset();
      #12;
      push_model();
      pop_check("reset");
      @(negedge clk);
      rst = 1'b0;

      // three plain fetches
      step("run0", 1'b0, 1'b0, 8'h00);
      step("run1", 1'b0, 1'b0, 8'h00);
      step("run2", 1'b0, 1'b0, 8'h00);
      check("run_cnt3", {16'h0, fetch_count}, 32'd3);
      check("run_instr2", if_id_instr, 32'h00200113);

      // stall holds everything
      step("stall0", 1'b1, 1'b0, 8'h00);
      step("stall1", 1'b1, 1'b0, 8'h00);
      step("release", 1'b0, 1'b0, 8'h00);

      // redirect to 0x48 gives one bubble then word 18
      step("redir48", 1'b0, 1'b1, 8'h48);
      step("after48", 1'b0, 1'b0, 8'h00);
      check("word18_pc", {24'h0, if_id_pc}, 32'h48);

      // redirect wins over stall
      step("redir_stall", 1'b1, 1'b1, 8'h20);
      step("after20", 1'b0, 1'b0, 8'h00);

      // consecutive redirects stay bubbles
      step("redir_a", 1'b0, 1'b1, 8'h30);
      step("redir_b", 1'b0, 1'b1, 8'hFC);

      // wrap at 0xFC
      step("wrap", 1'b0, 1'b0, 8'h00);
      check("wrap_pc4", {24'h0, if_id_pc_plus4}, 32'h00);
      step("after_wrap", 1'b0, 1'b0, 8'h00);

      // misaligned redirect and stickiness
      step("misalign", 1'b0, 1'b1, 8'h4A);
      step("mis_stall", 1'b1, 1'b0, 8'h00);
      step("mis_run", 1'b0, 1'b0, 8'h00);
      step("mis_redir_ok", 1'b0, 1'b1, 8'h08);

      // async reset mid-redirect/stall, checked between edges
      stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 8'h77;
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      push_model();
      pop_check("async_reset");
      @(negedge clk);
      rst = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
      step("post_reset", 1'b0, 1'b0, 8'h00);

      // counter saturation
      stall = 1'b0; redirect_valid = 1'b0;
      for (int i = 0; i < 65540; i++) begin
         model_edge(1'b0, 1'b0, 8'h00);
         @(posedge clk);
      end
      #1;
      step("sat", 1'b0, 1'b0, 8'h00);
      check("sat_cnt", {16'h0, fetch_count}, 32'h0000FFFF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
